// File: rtl/cmsdk_ahb_to_apb_responder_if.sv
// AHB-Lite slave-side and APB master-side signals of the AHB-to-APB responder.
// PSTRB/PPROT exist only when AHB_APB_BRIDGE_APB4_EN is defined.
interface cmsdk_ahb_to_apb_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [3:0]            HPROT;
  logic [31:0]           HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [31:0]           HRDATA;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
`ifdef AHB_APB_BRIDGE_APB4_EN
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
`endif

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
    input  PRDATA, PREADY, PSLVERR,
`ifdef AHB_APB_BRIDGE_APB4_EN
    output PSTRB, PPROT,
`endif
    output HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HWDATA, HREADY,
    output PRDATA, PREADY, PSLVERR,
`ifdef AHB_APB_BRIDGE_APB4_EN
    input  PSTRB, PPROT,
`endif
    input  HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/cmsdk_ahb_to_apb_responder.sv
// AHB-Lite responder converting each accepted transfer into one APB3 transfer; AHB waits until PREADY,
// APB errors give a two-cycle ERROR response. Define AHB_APB_BRIDGE_APB4_EN for PSTRB/PPROT sidebands.
module cmsdk_ahb_to_apb_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter bit REGISTER_RDATA = 1'b1
) (
  input logic                          HCLK,
  input logic                          HRESET,
  cmsdk_ahb_to_apb_responder_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_SAMPLE, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  write_q, write_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [31:0]           rdata_q, rdata_d;
`ifdef AHB_APB_BRIDGE_APB4_EN
  logic [3:0]            pstrb_q, pstrb_d, strb_dec;
  logic [2:0]            pprot_q, pprot_d;
`endif

  logic        accept, apb_ok, apb_err;
  logic        hreadyout, hresp, psel, penable;
  logic [31:0] hrdata;
  logic        unused_sig;

  // Any cycle that completes with HREADYOUT=1 doubles as an address-phase sample point.
  assign accept  = hreadyout & bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign apb_ok  = (state_q == ST_ACCESS) & bus.PREADY & ~bus.PSLVERR;
  assign apb_err = (state_q == ST_ACCESS) & bus.PREADY &  bus.PSLVERR;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      write_q  <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
`ifdef AHB_APB_BRIDGE_APB4_EN
      pstrb_q  <= '0;
      pprot_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      write_q  <= write_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
`ifdef AHB_APB_BRIDGE_APB4_EN
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: state_d = accept ? ST_SAMPLE : ST_IDLE;
      ST_SAMPLE:                 state_d = ST_SETUP;
      ST_SETUP:                  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (apb_err)
          state_d = ST_ERR1;
        else if (apb_ok)
          state_d = REGISTER_RDATA ? ST_DONE : (accept ? ST_SAMPLE : ST_IDLE);
      end
      ST_ERR1:                   state_d = ST_ERR2;
      default:                   state_d = ST_IDLE;
    endcase
  end

`ifdef AHB_APB_BRIDGE_APB4_EN
  always_comb begin
    strb_dec = 4'b1111;
    case (bus.HSIZE)
      3'd0:    strb_dec = 4'b0001 << bus.HADDR[1:0];
      3'd1:    strb_dec = 4'b0011 << {bus.HADDR[1], 1'b0};
      default: strb_dec = 4'b1111;
    endcase
  end
`endif

  always_comb begin
    paddr_d  = paddr_q;
    write_d  = write_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
`ifdef AHB_APB_BRIDGE_APB4_EN
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
`endif
    if (accept) begin
      paddr_d = {bus.HADDR[ADDR_WIDTH-1:2], 2'b00};
      write_d = bus.HWRITE;
`ifdef AHB_APB_BRIDGE_APB4_EN
      pstrb_d = bus.HWRITE ? strb_dec : 4'b0000;
      pprot_d = {~bus.HPROT[0], 1'b0, bus.HPROT[1]};
`endif
    end
    // HWDATA is only valid in the data phase, i.e. the SAMPLE cycle.
    if (state_q == ST_SAMPLE && write_q)
      pwdata_d = bus.HWDATA;
    if (apb_ok)
      rdata_d = write_q ? 32'h0 : bus.PRDATA;
  end

  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    unique case (state_q)
      ST_SAMPLE: hreadyout = 1'b0;
      ST_SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
      end
      ST_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = !REGISTER_RDATA && apb_ok;
        if (!REGISTER_RDATA && apb_ok && !write_q)
          hrdata = bus.PRDATA;
      end
      ST_DONE:   hrdata = rdata_q;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2:   hresp = 1'b1;
      default:   ;
    endcase
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = psel & write_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
`ifdef AHB_APB_BRIDGE_APB4_EN
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;
`endif

  assign unused_sig = ^{bus.HADDR, bus.HTRANS[0], bus.HSIZE, bus.HPROT};
endmodule
